// File: rtl/control_estados.sv
// control_estados: start/run/fault sequencer with synchronized inputs and a saturating fault counter.
// Define DEBOUNCE_EN to add a DEB_CYC-sample debounce filter after each synchronizer.
module control_estados #(
    parameter int T_ARRANQUE = 8,
    parameter int DEB_CYC    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inicio,
    input  logic       paro,
    input  logic       falla,
    input  logic       ack_falla,
    output logic [1:0] Estados,
    output logic       ocupado,
    output logic       listo,
    output logic [3:0] fallas
);

    typedef enum logic [1:0] {
        REPOSO   = 2'b00,
        ARRANQUE = 2'b01,
        MARCHA   = 2'b10,
        FALLA    = 2'b11
    } estado_t;

    if (T_ARRANQUE < 1 || T_ARRANQUE > 255) begin : g_bad_t_arranque
        $error("T_ARRANQUE out of range 1..255");
    end
    if (DEB_CYC < 1 || DEB_CYC > 15) begin : g_bad_deb_cyc
        $error("DEB_CYC out of range 1..15");
    end

`ifdef DEBOUNCE_EN
    localparam int FILL = 2 + DEB_CYC;
`else
    localparam int FILL = 2;
`endif
    localparam logic [4:0] FILL_L = 5'(FILL);
    localparam logic [7:0] T_M1   = 8'(T_ARRANQUE - 1);

    logic [3:0] raw;
    logic [3:0] sync1_q, sync2_q;
    logic [3:0] in_f;

    assign raw = {ack_falla, falla, paro, inicio};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef DEBOUNCE_EN
    localparam logic [3:0] DEB_M1 = 4'(DEB_CYC - 1);
    logic [3:0]       filt_q, filt_d;
    logic [3:0][3:0]  deb_cnt_q, deb_cnt_d;

    // Filter flips only after DEB_CYC consecutive samples disagreeing with it.
    always_comb begin
        filt_d    = filt_q;
        deb_cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (deb_cnt_q[i] == DEB_M1)
                    filt_d[i] = sync2_q[i];
                else
                    deb_cnt_d[i] = deb_cnt_q[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q    <= '0;
            deb_cnt_q <= '0;
        end else begin
            filt_q    <= filt_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign in_f = filt_q;
`else
    assign in_f = sync2_q;
`endif

    logic inicio_s, paro_s, falla_s, ack_falla_s;
    assign {ack_falla_s, falla_s, paro_s, inicio_s} = in_f;

    estado_t    state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] fallas_q, fallas_d;
    logic       ocupado_q, ocupado_d;
    logic       listo_q, listo_d;
    logic       prev_q, prev_d;
    logic       armed_q, armed_d;
    logic [4:0] fill_q, fill_d;
    logic       start;

    // Start is armed only once inicio has been seen low through a filled input pipeline,
    // so a level held across reset release never counts as an edge.
    always_comb begin
        fill_d  = (fill_q == FILL_L) ? fill_q : fill_q + 5'd1;
        armed_d = armed_q | ((fill_q == FILL_L) & ~inicio_s);
        prev_d  = inicio_s;
        start   = inicio_s & ~prev_q & armed_q;
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            REPOSO: begin
                if (falla_s)
                    state_d = FALLA;
                else if (start && !paro_s) begin
                    state_d = ARRANQUE;
                    cnt_d   = T_M1;
                end
            end
            ARRANQUE: begin
                if (falla_s)
                    state_d = FALLA;
                else if (paro_s)
                    state_d = REPOSO;
                else if (cnt_q == 8'd0)
                    state_d = MARCHA;
                else
                    cnt_d = cnt_q - 8'd1;
            end
            MARCHA: begin
                if (falla_s)
                    state_d = FALLA;
                else if (paro_s)
                    state_d = REPOSO;
            end
            default: begin
                if (ack_falla_s && !falla_s)
                    state_d = REPOSO;
            end
        endcase
        fallas_d  = (state_d == FALLA && state_q != FALLA && fallas_q != 4'hF) ? fallas_q + 4'd1 : fallas_q;
        ocupado_d = (state_d == ARRANQUE) || (state_d == MARCHA);
        listo_d   = (state_d == MARCHA);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= REPOSO;
            cnt_q     <= '0;
            fallas_q  <= '0;
            ocupado_q <= 1'b0;
            listo_q   <= 1'b0;
            prev_q    <= 1'b0;
            armed_q   <= 1'b0;
            fill_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fallas_q  <= fallas_d;
            ocupado_q <= ocupado_d;
            listo_q   <= listo_d;
            prev_q    <= prev_d;
            armed_q   <= armed_d;
            fill_q    <= fill_d;
        end
    end

    assign Estados = state_q;
    assign ocupado = ocupado_q;
    assign listo   = listo_q;
    assign fallas  = fallas_q;

endmodule

// File: tb/tb_control_estados.sv
// tb_control_estados: scoreboard bench for control_estados; expected {Estados,ocupado,listo,fallas}
// vectors are queued when stimulus is applied and popped once the input latency has elapsed.
module tb_control_estados;

`ifdef DEBOUNCE_EN
    localparam int LAT = 3 + 4;
`else
    localparam int LAT = 3;
`endif
    localparam int T = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       inicio = 1'b0, paro = 1'b0, falla = 1'b0, ack_falla = 1'b0;
    logic [1:0] Estados;
    logic       ocupado, listo;
    logic [3:0] fallas;

    control_estados #(.T_ARRANQUE(T), .DEB_CYC(4)) dut (
        .clk(clk), .reset(reset), .inicio(inicio), .paro(paro), .falla(falla),
        .ack_falla(ack_falla), .Estados(Estados), .ocupado(ocupado), .listo(listo), .fallas(fallas)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [1:0] e, input logic o, input logic l, input int f);
        exp_t x;
        x.tag = tag;
        x.v   = {e, o, l, 4'(f)};
        sb.push_back(x);
    endtask

    task automatic pop_check();
        exp_t x;
        if (sb.size() != 0) begin
            x = sb.pop_front();
            check(x.tag, {Estados, ocupado, listo, fallas}, x.v);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        #1 reset = 1'b0;
        #2;
        push("reset_async", 2'b00, 0, 0, 0);
        pop_check();
        tick(3);
        reset = 1'b1;
        push("idle", 2'b00, 0, 0, 0);
        tick(5);
        pop_check();

        // start, dwell exactly T cycles, then run
        inicio = 1'b1;
        push("start_wait", 2'b00, 0, 0, 0);
        push("start", 2'b01, 1, 0, 0);
        push("arranque_hold", 2'b01, 1, 0, 0);
        push("marcha", 2'b10, 1, 1, 0);
        tick(LAT - 1);
        pop_check();
        tick();
        pop_check();
        inicio = 1'b0;
        tick(T - 1);
        pop_check();
        tick();
        pop_check();

        // stop from run with inicio held high: no restart until a fresh edge
        inicio = 1'b1;
        push("marcha_inicio", 2'b10, 1, 1, 0);
        tick(LAT + 2);
        pop_check();
        paro = 1'b1;
        push("paro_wait", 2'b10, 1, 1, 0);
        push("paro_stop", 2'b00, 0, 0, 0);
        tick(LAT - 1);
        pop_check();
        tick();
        pop_check();
        paro = 1'b0;
        push("no_restart", 2'b00, 0, 0, 0);
        tick(10);
        pop_check();
        inicio = 1'b0;
        tick(LAT + 1);
        inicio = 1'b1;
        push("restart", 2'b01, 1, 0, 0);
        tick(LAT);
        pop_check();

        // fault beats stop in ARRANQUE; ack held while fault present does not exit
        inicio = 1'b0;
        falla = 1'b1;
        paro = 1'b1;
        push("falla_prio", 2'b11, 0, 0, 1);
        tick(LAT);
        pop_check();
        ack_falla = 1'b1;
        push("falla_hold_ack", 2'b11, 0, 0, 1);
        tick(LAT + 1);
        pop_check();
        falla = 1'b0;
        push("ack_exit", 2'b00, 0, 0, 1);
        tick(LAT);
        pop_check();
        ack_falla = 1'b0;
        paro = 1'b0;
        tick(LAT + 1);

        // fault counter saturation
        for (int i = 2; i <= 17; i++) begin
            falla = 1'b1;
            push("sat_enter", 2'b11, 0, 0, (i > 15) ? 15 : i);
            tick(LAT);
            pop_check();
            falla = 1'b0;
            ack_falla = 1'b1;
            push("sat_exit", 2'b00, 0, 0, (i > 15) ? 15 : i);
            tick(LAT);
            pop_check();
            ack_falla = 1'b0;
            tick(LAT);
        end

        // reset mid-ARRANQUE with inicio held high
        tick(LAT + 1);
        inicio = 1'b1;
        push("arr_before_rst", 2'b01, 1, 0, 15);
        tick(LAT + 2);
        pop_check();
        reset = 1'b0;
        #2;
        push("rst_mid", 2'b00, 0, 0, 0);
        pop_check();
        tick(2);
        reset = 1'b1;
        push("no_start_release", 2'b00, 0, 0, 0);
        tick(20);
        pop_check();
        inicio = 1'b0;
        tick(LAT + 1);
        inicio = 1'b1;
        push("start_after_low", 2'b01, 1, 0, 0);
        tick(LAT);
        pop_check();
        inicio = 1'b0;

        // fault held across reset release: earliest reaction after LAT edges
        reset = 1'b0;
        falla = 1'b1;
        tick(2);
        reset = 1'b1;
        push("rel_wait", 2'b00, 0, 0, 0);
        push("rel_falla", 2'b11, 0, 0, 1);
        tick(LAT - 1);
        pop_check();
        tick();
        pop_check();
        falla = 1'b0;
        ack_falla = 1'b1;
        tick(LAT);
        ack_falla = 1'b0;
        tick(LAT);

`ifdef DEBOUNCE_EN
        inicio = 1'b1;
        tick(3);
        inicio = 1'b0;
        push("glitch", 2'b00, 0, 0, 1);
        tick(12);
        pop_check();
        inicio = 1'b1;
        tick(5);
        inicio = 1'b0;
        push("deb_wait", 2'b00, 0, 0, 1);
        push("deb_start", 2'b01, 1, 0, 1);
        tick(1);
        pop_check();
        tick();
        pop_check();
`endif

        check("sb_drained", 8'(sb.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
